// File: rtl/fifo_stim_pkg.sv
// rtl/fifo_stim_pkg.sv - shared types, state encodings and helpers for the fifo stimulus agent
package fifo_stim_pkg;

  localparam int HITW = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_PUSHPOP = 2'd3
  } act_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Saturating increment used by all statistics counters.
  function automatic logic [HITW-1:0] sat_inc(input logic [HITW-1:0] v, input logic en);
    return (en && (v != {HITW{1'b1}})) ? v + HITW'(1) : v;
  endfunction

endpackage

// File: rtl/fifo_stim_agent_if.sv
// rtl/fifo_stim_agent_if.sv - action command channel between the RL agent and the stimulus agent
interface fifo_stim_agent_if #(
  parameter int LENW = 4
);
  logic            act_valid;
  logic            act_ready;
  logic [1:0]      act_op;
  logic [LENW-1:0] act_len;
  logic            goal_sel;
  logic            act_done;

  modport master (
    output act_valid, act_op, act_len, goal_sel,
    input  act_ready, act_done
  );

  modport slave (
    input  act_valid, act_op, act_len, goal_sel,
    output act_ready, act_done
  );
endinterface

// File: rtl/fifo_stim_scoreboard.sv
// rtl/fifo_stim_scoreboard.sv - shadow occupancy model, data/count checks, hit counters and reward
module fifo_stim_scoreboard
  import fifo_stim_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 beat_blocked_i,
  input  logic                 goal_sel_i,
  input  logic [WIDTH-1:0]     fifo_dataout_i,
  input  logic [LOG2DEPTH:0]   fifo_count_i,
  output logic [LOG2DEPTH:0]   shadow_o,
  output logic                 reward_o,
  output logic [HITW-1:0]      full_hits_o,
  output logic [HITW-1:0]      empty_hits_o,
  output logic [HITW-1:0]      blocked_o,
  output logic                 data_err_o,
  output logic                 count_err_o
);

  localparam logic [LOG2DEPTH:0] DEPTH_C = (LOG2DEPTH+1)'(DEPTH);
  localparam logic [LOG2DEPTH:0] ONE_C   = (LOG2DEPTH+1)'(1);

  logic [LOG2DEPTH:0] shadow_q, shadow_d;
  logic [WIDTH-1:0]   rd_seq_q;
  logic [HITW-1:0]    full_hits_q, empty_hits_q, blocked_q;
  logic               reward_q, data_err_q, count_err_q;
  logic               full_enter, empty_enter;

  // Post-update shadow occupancy and full/empty entry detection.
  always_comb begin
    shadow_d = shadow_q;
    case ({push_i, pop_i})
      2'b10:   shadow_d = shadow_q + ONE_C;
      2'b01:   shadow_d = shadow_q - ONE_C;
      default: shadow_d = shadow_q;
    endcase
    full_enter  = (shadow_q != DEPTH_C) && (shadow_d == DEPTH_C);
    empty_enter = (shadow_q != '0) && (shadow_d == '0);
  end

  // Shadow, read sequence, sticky checks, statistics and reward pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      rd_seq_q     <= '0;
      full_hits_q  <= '0;
      empty_hits_q <= '0;
      blocked_q    <= '0;
      reward_q     <= 1'b0;
      data_err_q   <= 1'b0;
      count_err_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (pop_i) begin
        rd_seq_q <= rd_seq_q + WIDTH'(1);
        if (fifo_dataout_i != rd_seq_q) data_err_q <= 1'b1;
      end
      if (fifo_count_i != shadow_d) count_err_q <= 1'b1;
      full_hits_q  <= sat_inc(full_hits_q, full_enter);
      empty_hits_q <= sat_inc(empty_hits_q, empty_enter);
      blocked_q    <= sat_inc(blocked_q, beat_blocked_i);
      reward_q     <= goal_sel_i ? empty_enter : full_enter;
    end
  end

  assign shadow_o     = shadow_q;
  assign reward_o     = reward_q;
  assign full_hits_o  = full_hits_q;
  assign empty_hits_o = empty_hits_q;
  assign blocked_o    = blocked_q;
  assign data_err_o   = data_err_q;
  assign count_err_o  = count_err_q;

endmodule

// File: rtl/fifo_stim_agent.sv
// rtl/fifo_stim_agent.sv - burst producer/consumer driving a fifo from RL action commands
module fifo_stim_agent
  import fifo_stim_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3,
  parameter int LENW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_stim_agent_if.slave   act,
  output logic               push,
  output logic               pop,
  output logic [WIDTH-1:0]   datain,
  input  logic [WIDTH-1:0]   fifo_dataout,
  input  logic [LOG2DEPTH:0] fifo_count,
  output logic               reward,
  output logic [HITW-1:0]    full_hits,
  output logic [HITW-1:0]    empty_hits,
  output logic [HITW-1:0]    blocked,
  output logic               data_err,
  output logic               count_err
);

  localparam logic [LOG2DEPTH:0] DEPTH_C = (LOG2DEPTH+1)'(DEPTH);

  logic [1:0]         state_q, state_d;
  act_op_e            op_q, op_d;
  logic [LENW-1:0]    len_q, len_d;
  logic [WIDTH-1:0]   wr_seq_q, wr_seq_d;
  logic [LOG2DEPTH:0] shadow;
  logic               run, push_ok, pop_ok, beat_blocked;

  // Guard uses only registered state so push/pop never depend on fifo outputs.
  always_comb begin
    run          = (state_q == ST_RUN);
    pop_ok       = ((op_q == OP_POP) || (op_q == OP_PUSHPOP)) && (shadow != '0);
    push_ok      = ((op_q == OP_PUSH) || (op_q == OP_PUSHPOP)) && ((shadow < DEPTH_C) || pop_ok);
    push         = run && push_ok;
    pop          = run && pop_ok;
    beat_blocked = run && !push_ok && !pop_ok;
  end

  // Command FSM: accept in IDLE, one beat per cycle in RUN, completion pulse in DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    wr_seq_d = wr_seq_q;
    if (push) wr_seq_d = wr_seq_q + WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (act.act_valid) begin
          op_d    = act_op_e'(act.act_op);
          len_d   = act.act_len;
          state_d = ((act.act_len != '0) && (act.act_op != OP_NOP)) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        len_d = len_q - LENW'(1);
        if (len_q == LENW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      len_q    <= '0;
      wr_seq_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      wr_seq_q <= wr_seq_d;
    end
  end

  assign datain        = wr_seq_q;
  assign act.act_ready = (state_q == ST_IDLE);
  assign act.act_done  = (state_q == ST_DONE);

  fifo_stim_scoreboard #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .LOG2DEPTH (LOG2DEPTH)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (push),
    .pop_i          (pop),
    .beat_blocked_i (beat_blocked),
    .goal_sel_i     (act.goal_sel),
    .fifo_dataout_i (fifo_dataout),
    .fifo_count_i   (fifo_count),
    .shadow_o       (shadow),
    .reward_o       (reward),
    .full_hits_o    (full_hits),
    .empty_hits_o   (empty_hits),
    .blocked_o      (blocked),
    .data_err_o     (data_err),
    .count_err_o    (count_err)
  );

endmodule

// File: tb/tb_fifo_stim_agent.sv
// tb/tb_fifo_stim_agent.sv - scoreboard bench for fifo_stim_agent with a behavioural fifo
module tb_fifo_stim_agent;
  import fifo_stim_pkg::*;

  localparam int WIDTH = 8, DEPTH = 8, LOG2DEPTH = 3, LENW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stim_agent_if #(.LENW(LENW)) act_if();

  logic             push, pop, reward, data_err, count_err;
  logic [WIDTH-1:0] datain, fifo_dataout;
  logic [3:0]       fifo_count;
  logic [7:0]       full_hits, empty_hits, blocked;

  fifo_stim_agent #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH), .LENW(LENW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .act          (act_if),
    .push         (push),
    .pop          (pop),
    .datain       (datain),
    .fifo_dataout (fifo_dataout),
    .fifo_count   (fifo_count),
    .reward       (reward),
    .full_hits    (full_hits),
    .empty_hits   (empty_hits),
    .blocked      (blocked),
    .data_err     (data_err),
    .count_err    (count_err)
  );

  // behavioural show-ahead fifo with fault hooks
  logic [7:0] mem [0:7];
  logic [2:0] wp, rp;
  logic [3:0] cnt, cnt_nx;
  logic       m_push, m_pop, flip, cnt_off;
  assign m_pop        = pop && (cnt != 4'd0);
  assign m_push       = push && ((cnt != 4'd8) || m_pop);
  assign cnt_nx       = cnt + {3'b0, m_push} - {3'b0, m_pop};
  assign fifo_count   = cnt_nx + {3'b0, cnt_off};
  assign fifo_dataout = mem[rp] ^ {7'b0, flip};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (m_push) begin mem[wp] <= datain; wp <= wp + 3'd1; end
      if (m_pop) rp <= rp + 3'd1;
      cnt <= cnt_nx;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lat; int npush; int npop; int rew; int blk; int fh; int eh; int derr; int cerr;
  } done_t;

  done_t exp_done_q[$];
  int    exp_push_q[$];

  task automatic exp_done(input int lat, input int np, input int nq, input int rew, input int blk,
                          input int fh, input int eh, input int derr, input int cerr);
    done_t d;
    d.lat = lat; d.npush = np; d.npop = nq; d.rew = rew; d.blk = blk;
    d.fh = fh; d.eh = eh; d.derr = derr; d.cerr = cerr;
    exp_done_q.push_back(d);
  endtask

  task automatic exp_pushes(input int first, input int n);
    for (int i = 0; i < n; i++) exp_push_q.push_back((first + i) % 256);
  endtask

  // monitor: compares pushed data and completion records against the queues
  int cyc = 0, acc_cyc = 0, n_push = 0, n_pop = 0, n_rew = 0;
  always @(negedge clk) begin
    done_t e;
    if (!rst_n) begin
      n_push = 0; n_pop = 0; n_rew = 0;
    end else begin
      cyc++;
      if (act_if.act_valid && act_if.act_ready) begin
        acc_cyc = cyc; n_push = 0; n_pop = 0; n_rew = 0;
      end
      if (push) begin
        n_push++;
        if (exp_push_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_push: got datain=%0d with nothing expected", datain);
        end else check("datain", int'(datain), exp_push_q.pop_front());
      end
      if (pop) n_pop++;
      if (reward) n_rew++;
      if (act_if.act_done) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got act_done with nothing expected");
        end else begin
          e = exp_done_q.pop_front();
          check("latency", cyc - acc_cyc, e.lat);
          check("push_beats", n_push, e.npush);
          check("pop_beats", n_pop, e.npop);
          check("rewards", n_rew, e.rew);
          check("blocked", int'(blocked), e.blk);
          check("full_hits", int'(full_hits), e.fh);
          check("empty_hits", int'(empty_hits), e.eh);
          check("data_err", int'(data_err), e.derr);
          check("count_err", int'(count_err), e.cerr);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int len, input logic goal);
    @(posedge clk); #1;
    act_if.act_valid = 1'b1;
    act_if.act_op    = op;
    act_if.act_len   = LENW'(len);
    act_if.goal_sel  = goal;
    @(posedge clk); #1;
    act_if.act_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (act_if.act_done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no act_done within 40 cycles, required one");
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input logic goal);
    issue(op, len, goal);
    wait_done();
  endtask

  initial begin
    act_if.act_valid = 1'b0;
    act_if.act_op    = 2'd0;
    act_if.act_len   = '0;
    act_if.goal_sel  = 1'b0;
    flip = 1'b0;
    cnt_off = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_act_ready", int'(act_if.act_ready), 1);
    check("rst_act_done", int'(act_if.act_done), 0);
    check("rst_push", int'(push), 0);
    check("rst_pop", int'(pop), 0);
    check("rst_datain", int'(datain), 0);
    check("rst_reward", int'(reward), 0);
    check("rst_counters", int'(full_hits) + int'(empty_hits) + int'(blocked), 0);
    check("rst_errs", int'(data_err) + int'(count_err), 0);
    rst_n = 1'b1;

    // fill to full, full goal
    exp_pushes(0, 8);
    exp_done(9, 8, 0, 1, 0, 1, 0, 0, 0);
    run_cmd(OP_PUSH, 8, 1'b0);

    // pushes into a full fifo are all suppressed
    exp_done(4, 0, 0, 0, 3, 1, 0, 0, 0);
    run_cmd(OP_PUSH, 3, 1'b0);

    // NOP and zero length complete in one cycle
    exp_done(1, 0, 0, 0, 3, 1, 0, 0, 0);
    run_cmd(OP_NOP, 5, 1'b0);
    exp_done(1, 0, 0, 0, 3, 1, 0, 0, 0);
    run_cmd(OP_PUSH, 0, 1'b0);

    // drain to empty, empty goal
    exp_done(9, 0, 8, 1, 3, 1, 1, 0, 0);
    run_cmd(OP_POP, 8, 1'b1);

    // push+pop from empty: first beat push only
    exp_pushes(8, 4);
    exp_done(5, 4, 3, 0, 3, 1, 1, 0, 0);
    run_cmd(OP_PUSHPOP, 4, 1'b1);

    // corrupted pop data
    flip = 1'b1;
    exp_done(2, 0, 1, 1, 3, 1, 2, 1, 0);
    run_cmd(OP_POP, 1, 1'b1);
    flip = 1'b0;

    // occupancy off by one
    cnt_off = 1'b1;
    exp_pushes(12, 1);
    exp_done(2, 1, 0, 0, 3, 1, 2, 1, 1);
    run_cmd(OP_PUSH, 1, 1'b0);
    cnt_off = 1'b0;

    // reset on beat 2 of 5
    exp_pushes(13, 2);
    issue(OP_PUSH, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_push", int'(push), 0);
    check("midrst_pop", int'(pop), 0);
    check("midrst_act_done", int'(act_if.act_done), 0);
    check("midrst_reward", int'(reward), 0);
    check("midrst_act_ready", int'(act_if.act_ready), 1);
    check("midrst_blocked", int'(blocked), 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_pushes(0, 1);
    exp_done(2, 1, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(OP_PUSH, 1, 1'b0);

    repeat (2) @(negedge clk);
    check("push_q_drained", exp_push_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
